// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with internal word-addressed data RAM, multi-cycle access and branch resolve.
// Build option MEM_ALIGN_CHECK_EN: suppress misaligned data accesses and raise sticky o_misalign_err.
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [1:0]  i_Mem_WB,
    input  logic        i_read_En,
    input  logic        i_write_En,
    input  logic        i_Mem_Br,
    input  logic        i_Zero,
    input  logic [31:0] i_DataAddress,
    input  logic [31:0] i_WriteData,
    input  logic [4:0]  i_dest,
    output logic        o_PCSrc,
    output logic        o_stall,
    output logic        o_RegWrite,
    output logic        o_MemtoReg,
    output logic [31:0] o_ReadData,
    output logic [31:0] o_ALUResult,
    output logic [4:0]  o_Write_Register,
    output logic        o_misalign_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_mem [DEPTH];
    logic          r_RegWrite;
    logic          r_MemtoReg;
    logic [31:0]   r_ReadData;
    logic [31:0]   r_ALUResult;
    logic [4:0]    r_Write_Register;

    logic [AW-1:0] w_idx;
    logic          w_req;
    logic          w_misalign;
    logic          w_stall;
    logic          w_access;
    logic          w_we;
    logic [31:0]   w_rdata;

    assign w_idx = i_DataAddress[AW+1:2];
    assign w_req = i_read_En | i_write_En;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_req & (i_DataAddress[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Stall covers every cycle of a multi-cycle access except the completing one.
    assign w_stall  = (r_state == S_IDLE) ? (w_req && (MEM_LAT > 1)) : (r_cnt > 4'd1);
    assign w_access = ~w_stall;
    assign w_we     = w_access & i_write_En & ~w_misalign;
    // Combinational read of the current word gives read-before-write when both enables are set.
    assign w_rdata  = (i_read_En & ~w_misalign) ? r_mem[w_idx] : 32'd0;

    assign o_PCSrc          = i_Mem_Br & i_Zero;
    assign o_stall          = w_stall;
    assign o_RegWrite       = r_RegWrite;
    assign o_MemtoReg       = r_MemtoReg;
    assign o_ReadData       = r_ReadData;
    assign o_ALUResult      = r_ALUResult;
    assign o_Write_Register = r_Write_Register;

    // RAM contents survive reset; a store pending when reset hits is simply dropped.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_we) begin
            r_mem[w_idx] <= i_WriteData;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if (w_access && w_misalign) begin
            r_misalign <= 1'b1;
        end
    end

    assign o_misalign_err = r_misalign;
`else
    assign o_misalign_err = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= 4'd0;
            r_RegWrite       <= 1'b0;
            r_MemtoReg       <= 1'b0;
            r_ReadData       <= 32'd0;
            r_ALUResult      <= 32'd0;
            r_Write_Register <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_stall) begin
                        r_state <= S_BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (w_stall) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase

            if (w_stall) begin
                r_RegWrite       <= 1'b0;
                r_MemtoReg       <= 1'b0;
                r_ReadData       <= 32'd0;
                r_ALUResult      <= 32'd0;
                r_Write_Register <= 5'd0;
            end else begin
                r_RegWrite       <= i_Mem_WB[1];
                r_MemtoReg       <= i_Mem_WB[0];
                r_ReadData       <= w_rdata;
                r_ALUResult      <= i_DataAddress;
                r_Write_Register <= i_dest;
            end
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 32-bit five-stage pipeline: consumes the EX/MEM register outputs of the execute stage, performs data-memory reads/writes against an internal word-addressed data RAM with configurable access latency, resolves the branch, and registers results into MEM/WB. It drives `Write_Register`/`RegWrite` back to the forwarding unit and asserts `stall` to freeze upstream stages during multi-cycle accesses.

## Interface
- `DEPTH`, 256: data-memory words; power of two.
- `MEM_LAT`, 1: access latency in cycles, ≥1.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Mem_WB` in 2: from EX/MEM; [1]=RegWrite, [0]=MemtoReg.
- `read_En` in 1: load request.
- `write_En` in 1: store request.
- `Mem_Br` in 1: branch instruction in MEM.
- `Zero` in 1: ALU zero flag.
- `DataAddress` in 32: byte address / ALU result.
- `WriteData` in 32: store data.
- `dest` in 5: destination register.
- `PCSrc` out 1: taken branch = `Mem_Br & Zero`, combinational.
- `stall` out 1: hold PC, IF/ID, ID/EX, EX/MEM.
- `RegWrite` out 1: MEM/WB write enable.
- `MemtoReg` out 1: MEM/WB writeback select.
- `ReadData` out 32: MEM/WB load data.
- `ALUResult` out 32: MEM/WB copy of `DataAddress`.
- `Write_Register` out 5: MEM/WB destination.
- `misalign_err` out 1: sticky misaligned-access flag (see Configuration).

## Operation
- Index = `DataAddress[log2(DEPTH)+1:2]`; upper bits ignored (address wraps modulo DEPTH words). RAM contents are not reset.
- FSM states: IDLE, BUSY. 4-bit down-counter `cnt`.
- IDLE, no request: MEM/WB loads `Mem_WB`, `DataAddress`, `dest`, `ReadData`=0; no stall.
- IDLE, request (`read_En|write_En`), `MEM_LAT`=1: access completes this cycle; store commits and MEM/WB loads at the edge.
- IDLE, request, `MEM_LAT`≥2: `stall`=1, `cnt`←`MEM_LAT`-1, →BUSY; MEM/WB loads bubble (all fields 0).
- BUSY, `cnt`>1: `stall`=1, `cnt` decrements, MEM/WB loads bubble.
- BUSY, `cnt`=1: `stall`=0; store commits, load data captured, MEM/WB loads result; →IDLE.
- Upstream holds EX/MEM inputs constant while `stall`=1; block samples the request only in IDLE and at completion.
- `read_En` and `write_En` both high: store commits; `ReadData` returns pre-write contents (read-before-write).
- `MemtoReg`/`RegWrite` pass from `Mem_WB` unchanged; the block does not qualify them by `read_En`.
- `PCSrc` is independent of stall and FSM.

## Timing
- Reset: state IDLE, `cnt`=0, `stall`=0, `RegWrite`=0, `MemtoReg`=0, `ReadData`=0, `ALUResult`=0, `Write_Register`=0, `misalign_err`=0. `PCSrc` follows inputs.
- Reset during BUSY: pending store discarded, RAM unchanged, IDLE next cycle.
- Non-memory op latency: 1 cycle to MEM/WB.
- Memory op: `stall` high exactly `MEM_LAT`-1 cycles; result in MEM/WB `MEM_LAT` edges after request is first presented.
- Back-to-back memory ops: second begins in IDLE the cycle after the first completes; no idle gap besides the stall.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a request with `DataAddress[1:0]`≠0 performs no RAM write, returns `ReadData`=0, follows normal latency/stall, and sets `misalign_err` (sticky until `rst`).
- Undefined: low address bits ignored (word-aligned access), `misalign_err` tied 0.

## Test plan
- `MEM_LAT`=1: store 0xDEADBEEF @0x10, then load @0x10 with `Mem_WB`=2'b11, `dest`=5 → next-cycle `ReadData`=0xDEADBEEF, `RegWrite`=1, `Write_Register`=5, `stall` never high.
- `MEM_LAT`=3: load request → `stall` high 2 cycles, MEM/WB bubble (`RegWrite`=0) for 2 edges, result on 3rd edge.
- Simultaneous `read_En`/`write_En` @0x20 holding 0x1111, data 0x2222 → `ReadData`=0x1111; subsequent load returns 0x2222.
- Address wrap, DEPTH=256: store 0xA5 @0x400 → load @0x0 returns 0xA5.
- `rst` asserted mid-BUSY store (`MEM_LAT`=4) → `stall`=0 next cycle, target word unchanged; `Mem_Br`=1,`Zero`=1 → `PCSrc`=1 throughout.
- With `MEM_ALIGN_CHECK_EN`: store @0x13 → RAM unchanged, `misalign_err`=1 and stays 1 until `rst`.
